fractcam_update_ctrl: RTL and testbench
=======================================

Name: fractcam_update_ctrl

Overview:
- Sequencer and arbiter in front of one fractcam instance; owns its search_key, wr_enable and rules inputs.
- Shares the array between a lookup stream and a rule-update stream.
- Turns each single-entry update (value/mask/valid) into the 32-cycle LUTRAM address sweep. A per-entry shadow preserves the other 7 entries of the same 8-entry row.
- Registers match results, adds hit flag and lowest-index priority encode; clears the array after reset.

Parameters:
- TCAM_WIDTH, 5, key width; multiple of 5.
- TCAM_DEPTH, 64, entries; multiple of 8.
- MATCH_LATENCY, 1, cycles from tcam_search_key register to valid tcam_match; range 0..4.
- localparam ADDR_W = clog2(TCAM_DEPTH); COLS = TCAM_WIDTH/5; ROWS = TCAM_DEPTH/8.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- upd_valid  in  1  update request.
- upd_ready  out  1  update accepted when upd_valid && upd_ready.
- upd_addr  in  ADDR_W  target entry.
- upd_value  in  TCAM_WIDTH  rule value.
- upd_mask  in  TCAM_WIDTH  1 = care bit.
- upd_enable  in  1  1 = install rule, 0 = invalidate entry.
- upd_done  out  1  one-cycle pulse on last write cycle.
- srch_valid  in  1  lookup request.
- srch_ready  out  1  lookup accepted when srch_valid && srch_ready.
- srch_key  in  TCAM_WIDTH  lookup key.
- res_valid  out  1  result strobe; no backpressure.
- res_match  out  TCAM_DEPTH  per-entry match vector.
- res_hit  out  1  |res_match.
- res_index  out  ADDR_W  lowest set index of res_match; 0 when no hit.
- tcam_search_key  out  TCAM_WIDTH  to fractcam search_key.
- tcam_wr_enable  out  ROWS  to fractcam wr_enable.
- tcam_rules  out  COLS*8  to fractcam rules.
- tcam_match  in  TCAM_DEPTH  from fractcam match.

Behaviour:
- States: CLEAR, IDLE, WRITE; 5-bit sweep counter cnt.
- Reset (async, rst_n low):
  - state = CLEAR, cnt = 0, shadow valid bits = 0, prio_upd = 1.
  - All outputs 0, including tcam_* and res_*; readies 0.
- CLEAR:
  - 32 cycles; tcam_search_key = {COLS{cnt}}, tcam_wr_enable = all ones, tcam_rules = 0.
  - cnt 0..31, then IDLE. This wipes all TCAM contents regardless of INIT.
- Arbitration in IDLE (round-robin):
  - upd_ready = (state==IDLE) && (prio_upd || !srch_valid).
  - srch_ready = (state==IDLE) && !(upd_valid && prio_upd).
  - prio_upd is set on a search accept and cleared on upd_done.
  - With a single active requester, that requester is served back-to-back.
  - With continuous contention, grants alternate; search stall is at most 33 cycles.
- Search accepted at cycle T:
  - tcam_search_key = {COLS{srch_key[4:0] per column}} registered, visible T+1; tcam_wr_enable = 0.
  - tcam_match sampled at T+1+MATCH_LATENCY; res_* registered, valid at T+2+MATCH_LATENCY for one cycle.
  - Throughput 1/cycle; results are in order.
  - Searches already in flight when a write starts complete normally with pre-write contents.
- Update accepted at cycle T:
  - Latch addr/value/mask/enable; enter WRITE with cnt = 0.
  - Cycles T+1..T+32: tcam_search_key = {COLS{cnt}}, tcam_wr_enable = one-hot(upd_addr>>3).
  - For column c and k = 0..7, entry e = row*8+k: tcam_rules[c*8+k] = v_e && (((cnt ^ val_e[c*5+:5]) & msk_e[c*5+:5]) == 0).
  - Entry e uses the latched request if e == upd_addr; otherwise it uses its shadow.
  - Invalidate means v = 0, so that entry's bit is 0 at every address.
  - On the cycle with cnt = 31: upd_done = 1 and the shadow entry is committed (value, mask, valid = upd_enable); next state IDLE.
  - Both readies stay 0 throughout WRITE.
- Rows other than the target are never written.
- Reset mid-WRITE or mid-CLEAR: the sweep is abandoned and shadow invalidated; CLEAR restarts after release. No partial upd_done is issued.
- res_index: priority encode, lowest index wins.

Test Plan:
- Reset release (defaults) -> 32 cycles with tcam_wr_enable=8'hFF, tcam_rules=0, keys 0..31, upd_ready=srch_ready=0 -> then srch_ready=1; search key 0 -> res_hit=0, res_match=0 at T+3.
- Update addr 3, value 5'b10100, mask 5'b11100, enable 1 -> 32 cycles wr_enable=8'h01, rules[3]=1 only for keys 20..23, upd_done on cycle 32; search key 21 -> res_match=64'h8, res_hit=1, res_index=3.
- Then update addr 5, value 0, mask 0 -> rules[3] still 1 for keys 20..23, rules[5]=1 all keys; search 21 -> match 64'h28, index 3; search 7 -> 64'h20, index 5.
- Invalidate addr 3 (enable 0) -> search 21 -> match 64'h20, index 5; entry 3 bit 0 for every sweep address.
- upd_valid and srch_valid held high together in IDLE -> grant sequence update, search, update, search; each search accepted within 33 cycles of the previous.
- rst_n low at cnt=10 of a write -> all outputs 0 immediately, no upd_done; after release, CLEAR sweep; search key 21 -> res_hit=0.

Source files
------------

// File: rtl/fractcam_update_ctrl.sv
// Front-end sequencer for one fractcam: wipes the array after reset, arbitrates lookups
// against single-entry rule updates, and expands each update into a 32-address LUTRAM sweep.
//
// state | meaning
// CLEAR | post-reset wipe, every row written with 0 at addresses 0..31
// IDLE  | lookups and update requests arbitrated round-robin
// WRITE | 32-cycle sweep of the target row, cnt = address on the bus
module fractcam_update_ctrl #(
   parameter  int TCAM_WIDTH    = 5,
   parameter  int TCAM_DEPTH    = 64,
   parameter  int MATCH_LATENCY = 1,
   localparam int ADDR_W        = $clog2(TCAM_DEPTH),
   localparam int COLS          = TCAM_WIDTH / 5,
   localparam int ROWS          = TCAM_DEPTH / 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    upd_valid,
   output logic                    upd_ready,
   input  logic [ADDR_W-1:0]       upd_addr,
   input  logic [TCAM_WIDTH-1:0]   upd_value,
   input  logic [TCAM_WIDTH-1:0]   upd_mask,
   input  logic                    upd_enable,
   output logic                    upd_done,
   input  logic                    srch_valid,
   output logic                    srch_ready,
   input  logic [TCAM_WIDTH-1:0]   srch_key,
   output logic                    res_valid,
   output logic [TCAM_DEPTH-1:0]   res_match,
   output logic                    res_hit,
   output logic [ADDR_W-1:0]       res_index,
   output logic [TCAM_WIDTH-1:0]   tcam_search_key,
   output logic [ROWS-1:0]         tcam_wr_enable,
   output logic [COLS*8-1:0]       tcam_rules,
   input  logic [TCAM_DEPTH-1:0]   tcam_match
);
   localparam int PIPE_W = MATCH_LATENCY + 1;

   typedef enum logic [1:0] {CLEAR, IDLE, WRITE} state_t;

   state_t                  state;
   logic [4:0]              cnt;
   logic                    prio_upd;
   logic [ADDR_W-1:0]       lat_addr;
   logic [TCAM_WIDTH-1:0]   lat_value;
   logic [TCAM_WIDTH-1:0]   lat_mask;
   logic                    lat_enable;
   logic [TCAM_DEPTH-1:0]   sh_v;
   logic [TCAM_WIDTH-1:0]   sh_value [TCAM_DEPTH];
   logic [TCAM_WIDTH-1:0]   sh_mask  [TCAM_DEPTH];
   logic [PIPE_W-1:0]       srch_pipe;

   logic                    upd_acc;
   logic                    srch_acc;
   logic                    commit;
   logic [ADDR_W-1:0]       sel_addr;
   logic [TCAM_WIDTH-1:0]   sel_value;
   logic [TCAM_WIDTH-1:0]   sel_mask;
   logic                    sel_enable;
   logic [4:0]              sweep_n;
   logic [ROWS-1:0]         wr_row;
   logic [COLS*8-1:0]       rules_next;
   logic [ADDR_W-1:0]       ent;
   logic                    ent_v;
   logic [TCAM_WIDTH-1:0]   ent_val;
   logic [TCAM_WIDTH-1:0]   ent_msk;
   logic [ADDR_W-1:0]       match_idx;

   assign upd_ready  = (state == IDLE) && (prio_upd || !srch_valid);
   assign srch_ready = (state == IDLE) && !(upd_valid && prio_upd);
   assign upd_acc    = upd_valid && upd_ready;
   assign srch_acc   = srch_valid && srch_ready;
   assign commit     = (state == WRITE) && (cnt == 5'd31);

   // On the accept cycle the request is not latched yet, so the sweep reads the inputs.
   assign sel_addr   = (state == IDLE) ? upd_addr   : lat_addr;
   assign sel_value  = (state == IDLE) ? upd_value  : lat_value;
   assign sel_mask   = (state == IDLE) ? upd_mask   : lat_mask;
   assign sel_enable = (state == IDLE) ? upd_enable : lat_enable;
   assign sweep_n    = (state == WRITE) ? cnt + 5'd1 : 5'd0;
   assign wr_row     = ROWS'(1) << (sel_addr >> 3);

   always_comb begin
      rules_next = '0;
      ent        = '0;
      ent_v      = 1'b0;
      ent_val    = '0;
      ent_msk    = '0;
      for (int k = 0; k < 8; k++) begin
         ent = (sel_addr & ~ADDR_W'(7)) | ADDR_W'(k);
         if (ent == sel_addr) begin
            ent_v   = sel_enable;
            ent_val = sel_value;
            ent_msk = sel_mask;
         end else begin
            ent_v   = sh_v[ent];
            ent_val = sh_value[ent];
            ent_msk = sh_mask[ent];
         end
         for (int c = 0; c < COLS; c++)
            rules_next[c*8+k] = ent_v && (((sweep_n ^ ent_val[c*5 +: 5]) & ent_msk[c*5 +: 5]) == 5'd0);
      end
   end

   always_comb begin
      match_idx = '0;
      for (int i = TCAM_DEPTH - 1; i >= 0; i--)
         if (tcam_match[i]) match_idx = ADDR_W'(i);
   end

   always_ff @(posedge clk) begin
      if (commit) begin
         sh_value[lat_addr] <= lat_value;
         sh_mask[lat_addr]  <= lat_mask;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= CLEAR;
         cnt             <= '0;
         prio_upd        <= 1'b1;
         sh_v            <= '0;
         lat_addr        <= '0;
         lat_value       <= '0;
         lat_mask        <= '0;
         lat_enable      <= 1'b0;
         srch_pipe       <= '0;
         upd_done        <= 1'b0;
         res_valid       <= 1'b0;
         res_match       <= '0;
         res_hit         <= 1'b0;
         res_index       <= '0;
         tcam_search_key <= '0;
         tcam_wr_enable  <= '0;
         tcam_rules      <= '0;
      end else begin
         upd_done  <= 1'b0;
         srch_pipe <= (srch_pipe << 1) | PIPE_W'(srch_acc);
         res_valid <= srch_pipe[MATCH_LATENCY];
         if (srch_pipe[MATCH_LATENCY]) begin
            res_match <= tcam_match;
            res_hit   <= |tcam_match;
            res_index <= match_idx;
         end
         case (state)
            CLEAR: begin
               tcam_rules <= '0;
               // Leave once address 31 has been on the bus with the write strobe.
               if ((tcam_wr_enable != '0) && (tcam_search_key[4:0] == 5'd31)) begin
                  state          <= IDLE;
                  tcam_wr_enable <= '0;
               end else begin
                  tcam_search_key <= {COLS{cnt}};
                  tcam_wr_enable  <= '1;
                  cnt             <= cnt + 5'd1;
               end
            end
            IDLE: begin
               tcam_wr_enable <= '0;
               tcam_rules     <= '0;
               if (upd_acc) begin
                  lat_addr        <= upd_addr;
                  lat_value       <= upd_value;
                  lat_mask        <= upd_mask;
                  lat_enable      <= upd_enable;
                  state           <= WRITE;
                  cnt             <= '0;
                  tcam_search_key <= {COLS{5'd0}};
                  tcam_wr_enable  <= wr_row;
                  tcam_rules      <= rules_next;
               end else if (srch_acc) begin
                  tcam_search_key <= srch_key;
                  prio_upd        <= 1'b1;
               end
            end
            WRITE: begin
               if (cnt == 5'd31) begin
                  state          <= IDLE;
                  cnt            <= '0;
                  tcam_wr_enable <= '0;
                  tcam_rules     <= '0;
                  prio_upd       <= 1'b0;
                  sh_v[lat_addr] <= lat_enable;
               end else begin
                  cnt             <= sweep_n;
                  tcam_search_key <= {COLS{sweep_n}};
                  tcam_rules      <= rules_next;
                  upd_done        <= (cnt == 5'd30);
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end
endmodule

// File: tb/tb_fractcam_update_ctrl.sv
// Bench for fractcam_update_ctrl: a LUTRAM-style fractcam stand-in plus an entry-table
// reference model (valid/value/mask per entry) that predicts sweeps and lookup results.
module tb_fractcam_update_ctrl;
   localparam int W    = 5;
   localparam int D    = 64;
   localparam int AW   = 6;
   localparam int ROWS = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          upd_valid, upd_ready, upd_enable, upd_done;
   logic [AW-1:0] upd_addr;
   logic [W-1:0]  upd_value, upd_mask;
   logic          srch_valid, srch_ready;
   logic [W-1:0]  srch_key;
   logic          res_valid, res_hit;
   logic [D-1:0]  res_match;
   logic [AW-1:0] res_index;
   logic [W-1:0]  tcam_search_key;
   logic [ROWS-1:0] tcam_wr_enable;
   logic [7:0]    tcam_rules;
   logic [D-1:0]  tcam_match;

   int n_assert = 0;
   int n_fail   = 0;

   fractcam_update_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr),
      .upd_value(upd_value), .upd_mask(upd_mask), .upd_enable(upd_enable),
      .upd_done(upd_done),
      .srch_valid(srch_valid), .srch_ready(srch_ready), .srch_key(srch_key),
      .res_valid(res_valid), .res_match(res_match), .res_hit(res_hit),
      .res_index(res_index),
      .tcam_search_key(tcam_search_key), .tcam_wr_enable(tcam_wr_enable),
      .tcam_rules(tcam_rules), .tcam_match(tcam_match)
   );

   always #5 clk = ~clk;

   // fractcam stand-in: per row, 32 addresses x 8 entry bits; match registered once.
   logic [7:0] mem [ROWS][32];
   bit         scramble = 1'b1;

   function automatic logic [D-1:0] lut_match(input logic [4:0] key);
      logic [D-1:0] m;
      for (int r = 0; r < ROWS; r++)
         for (int k = 0; k < 8; k++) m[r*8+k] = mem[r][key][k];
      return m;
   endfunction

   always @(posedge clk) begin
      if (scramble) begin
         for (int r = 0; r < ROWS; r++)
            for (int a = 0; a < 32; a++) mem[r][a] <= 8'($urandom);
      end else begin
         tcam_match <= lut_match(tcam_search_key);
         for (int r = 0; r < ROWS; r++)
            if (tcam_wr_enable[r]) mem[r][tcam_search_key] <= tcam_rules;
      end
   end

   // Reference: what each entry should currently hold.
   bit         ref_v   [D];
   logic [4:0] ref_val [D];
   logic [4:0] ref_msk [D];

   function automatic bit ent_hit(input int e, input logic [4:0] key);
      return ref_v[e] && (((key ^ ref_val[e]) & ref_msk[e]) == 5'd0);
   endfunction

   function automatic logic [D-1:0] ref_match(input logic [4:0] key);
      logic [D-1:0] m;
      for (int e = 0; e < D; e++) m[e] = ent_hit(e, key);
      return m;
   endfunction

   function automatic logic [AW-1:0] first_idx(input logic [D-1:0] m);
      for (int i = 0; i < D; i++) if (m[i]) return AW'(i);
      return '0;
   endfunction

   function automatic logic [95:0] all_outs();
      return {upd_ready, upd_done, srch_ready, res_valid, res_match, res_hit, res_index,
              tcam_search_key, tcam_wr_enable, tcam_rules};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_check();
      for (int j = 0; j < 32; j++) begin
         @(posedge clk); @(negedge clk);
         chk($sformatf("clear_addr%0d", j),
             {upd_ready, srch_ready, upd_done, tcam_search_key, tcam_wr_enable, tcam_rules, res_valid},
             {3'b000, 5'(j), 8'hFF, 8'h00, 1'b0});
      end
      @(posedge clk); @(negedge clk);
      chk("clear_exit", {upd_ready, srch_ready, tcam_wr_enable}, {2'b11, 8'h00});
      @(posedge clk); #1;
   endtask

   task automatic do_update(input int addr, input logic [4:0] val, input logic [4:0] msk,
                            input bit en, input int abort_at);
      int         waited = 0;
      int         row = addr / 8;
      logic [7:0] exp_rules;
      upd_valid = 1'b1; upd_addr = AW'(addr); upd_value = val; upd_mask = msk; upd_enable = en;
      @(negedge clk);
      while (!upd_ready && waited < 100) begin
         @(posedge clk); @(negedge clk);
         waited++;
      end
      chk("upd_accept", upd_ready, 1);
      @(posedge clk); #1;
      upd_valid = 1'b0;
      ref_v[addr] = en; ref_val[addr] = val; ref_msk[addr] = msk;
      for (int j = 0; j < 32; j++) begin
         @(negedge clk);
         if (j == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk("abort_outputs", all_outs(), 0);
            return;
         end
         for (int k = 0; k < 8; k++) exp_rules[k] = ent_hit(row*8 + k, 5'(j));
         chk($sformatf("sweep_a%0d_addr%0d", addr, j),
             {upd_ready, srch_ready, upd_done, tcam_search_key, tcam_wr_enable, tcam_rules},
             {2'b00, (j == 31), 5'(j), 8'(1) << row, exp_rules});
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("post_sweep", {upd_done, tcam_wr_enable}, 0);
      @(posedge clk); #1;
   endtask

   logic [4:0] skeys[$];

   // Back-to-back lookups; each result must appear exactly 3 cycles after its accept.
   task automatic search_burst();
      int           n = skeys.size();
      logic [D-1:0] exp_m[$];
      logic [D-1:0] exp;
      for (int i = 0; i < n + 3; i++) begin
         if (i < n) begin
            srch_valid = 1'b1; srch_key = skeys[i];
            exp_m.push_back(ref_match(skeys[i]));
         end else srch_valid = 1'b0;
         @(negedge clk);
         if (i < n) chk("srch_ready", srch_ready, 1);
         if (i >= 3) begin
            exp = exp_m[i-3];
            chk($sformatf("result_key%0d", skeys[i-3]),
                {res_valid, res_match, res_hit, res_index},
                {1'b1, exp, |exp, first_idx(exp)});
         end else chk("res_quiet", res_valid, 0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("res_strobe_end", res_valid, 0);
      @(posedge clk); #1;
      skeys.delete();
   endtask

   initial begin
      int gseq[$];
      int gcyc[$];
      int cyc;
      upd_valid = 0; upd_addr = '0; upd_value = '0; upd_mask = '0; upd_enable = 0;
      srch_valid = 0; srch_key = '0;
      for (int e = 0; e < D; e++) begin ref_v[e] = 0; ref_val[e] = '0; ref_msk[e] = '0; end

      repeat (3) @(posedge clk);
      scramble = 1'b0;
      @(negedge clk);
      chk("reset_outputs", all_outs(), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      clear_check();
      skeys.push_back(5'd0);
      search_burst();

      do_update(3, 5'b10100, 5'b11100, 1'b1, -1);
      skeys.push_back(5'd21);
      search_burst();

      do_update(5, 5'd0, 5'd0, 1'b1, -1);
      skeys.push_back(5'd21); skeys.push_back(5'd7);
      search_burst();

      do_update(3, 5'b10100, 5'b11100, 1'b0, -1);
      skeys.push_back(5'd21);
      search_burst();

      // Contention: both requesters held high; the previous search left update priority set.
      upd_valid = 1; upd_addr = 6'd40; upd_value = 5'd9; upd_mask = 5'h1F; upd_enable = 1;
      srch_valid = 1; srch_key = 5'd9;
      cyc = 0;
      while (gseq.size() < 4 && cyc < 300) begin
         @(negedge clk);
         if (upd_valid && upd_ready) begin gseq.push_back(1); gcyc.push_back(cyc); end
         else if (srch_valid && srch_ready) begin gseq.push_back(2); gcyc.push_back(cyc); end
         @(posedge clk); #1;
         cyc++;
      end
      upd_valid = 0; srch_valid = 0;
      ref_v[40] = 1; ref_val[40] = 5'd9; ref_msk[40] = 5'h1F;
      while (gseq.size() < 4) begin gseq.push_back(0); gcyc.push_back(1000); end
      chk("grant0_update", gseq[0], 1);
      chk("grant1_search", gseq[1], 2);
      chk("grant2_update", gseq[2], 1);
      chk("grant3_search", gseq[3], 2);
      chk("update_to_search_gap", gcyc[1] - gcyc[0], 33);
      chk("search_wait_le_33", (gcyc[3] - gcyc[1] - 1) <= 33, 1);
      repeat (5) @(posedge clk);
      #1;
      skeys.push_back(5'd9); skeys.push_back(5'd21);
      search_burst();

      // Random updates concentrated in rows 0-1 so neighbours rely on the shadow.
      for (int u = 0; u < 6; u++)
         do_update($urandom_range(0, 15), 5'($urandom), 5'($urandom),
                   ($urandom_range(0, 3) != 0), -1);
      for (int s = 0; s < 12; s++) begin
         if (s % 2 == 0) skeys.push_back(ref_val[$urandom_range(0, 15)]);
         else skeys.push_back(5'($urandom));
      end
      search_burst();

      // Reset in the middle of a sweep.
      do_update(12, 5'd3, 5'h1F, 1'b1, 10);
      for (int r = 0; r < 3; r++) begin
         @(negedge clk);
         chk("held_in_reset", all_outs(), 0);
      end
      @(posedge clk); #1;
      for (int e = 0; e < D; e++) ref_v[e] = 0;
      rst_n = 1'b1;
      clear_check();
      skeys.push_back(5'd21); skeys.push_back(5'd3);
      search_burst();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
